// File: rtl/braille_number_serializer.sv
// braille_number_serializer: streams a packed BCD number as a number-sign cell plus MSD-first Braille digit cells
module braille_number_serializer #(
  parameter int DIGITS = 4,
  parameter bit SUPPRESS_LZ = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  input  logic                  out_ready,
  output logic                  cell_valid,
  output logic [5:0]            cell_out,
  output logic                  cell_last,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [5:0] SIGN_CELL = 6'b111010;
  localparam logic [5:0] ENC [16] = '{
    6'b001110, 6'b000001, 6'b000101, 6'b000011, 6'b001011,
    6'b001001, 6'b000111, 6'b001111, 6'b001101, 6'b000110,
    6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000
  };
  typedef enum logic [1:0] {IDLE, SIGN, DIGIT, DONE} state_t;
  state_t state, state_d;
  logic [4*DIGITS-1:0] data, data_d;
  logic [IW-1:0] idx, idx_d;
  logic errf, errf_d, err_d;
  logic [3:0] cur, nib_d;
  function automatic logic [IW-1:0] first_idx(input logic [4*DIGITS-1:0] b);
    first_idx = SUPPRESS_LZ ? '0 : IW'(DIGITS - 1);
    if (SUPPRESS_LZ)
      for (int i = 0; i < DIGITS; i++)
        if (b[4*i +: 4] != 4'd0) first_idx = IW'(i);
  endfunction
  assign cur = data[4*idx +: 4];
  assign nib_d = data_d[4*idx_d +: 4];
  always_comb begin
    state_d = state;
    data_d = data;
    idx_d = idx;
    errf_d = errf;
    err_d = err;
    case (state)
      IDLE, DONE: begin
        state_d = start ? SIGN : IDLE;
        if (start) begin
          data_d = bcd_in;
          idx_d = first_idx(bcd_in);
          errf_d = 1'b0;
          err_d = 1'b0;
        end
      end
      SIGN: state_d = out_ready ? DIGIT : SIGN;
      DIGIT: if (out_ready) begin
        errf_d = errf | (cur > 4'd9);
        state_d = idx == '0 ? DONE : DIGIT;
        idx_d = idx == '0 ? idx : idx - IW'(1);
        err_d = idx == '0 ? errf_d : err;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      data <= '0;
      idx <= '0;
      errf <= 1'b0;
      err <= 1'b0;
      cell_valid <= 1'b0;
      cell_out <= '0;
      cell_last <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_d;
      data <= data_d;
      idx <= idx_d;
      errf <= errf_d;
      err <= err_d;
      cell_valid <= state_d == SIGN || state_d == DIGIT;
      busy <= state_d == SIGN || state_d == DIGIT;
      cell_out <= state_d == SIGN ? SIGN_CELL : state_d == DIGIT ? ENC[nib_d] : 6'd0;
      cell_last <= state_d == DIGIT && idx_d == '0;
      done <= state_d == DONE;
    end
  end
endmodule

// File: tb/tb_braille_number_serializer.sv
// tb_braille_number_serializer: randomized checks against a dot-level Braille reference model
module tb_braille_number_serializer;
  localparam int DOTS [10] = '{245, 1, 12, 14, 145, 15, 124, 1245, 125, 24};
  localparam int POS [7] = '{0, 0, 2, 4, 1, 3, 5};
  logic clk = 0;
  logic rst = 1;
  logic start1 = 0, start0 = 0, out_ready = 0;
  logic [15:0] bcd_in = '0;
  logic v1, l1, b1, d1, e1, v0, l0, b0, d0, e0;
  logic [5:0] c1, c0;
  logic sel0 = 0;
  logic v, l, bz, dn, er;
  logic [5:0] c;
  int errors = 0, checks = 0;
  logic [5:0] exp_c[$];
  bit exp_l[$];
  bit exp_err;
  braille_number_serializer #(.DIGITS(4), .SUPPRESS_LZ(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .bcd_in(bcd_in), .out_ready(out_ready),
    .cell_valid(v1), .cell_out(c1), .cell_last(l1), .busy(b1), .done(d1), .err(e1));
  braille_number_serializer #(.DIGITS(4), .SUPPRESS_LZ(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .bcd_in(bcd_in), .out_ready(out_ready),
    .cell_valid(v0), .cell_out(c0), .cell_last(l0), .busy(b0), .done(d0), .err(e0));
  assign v = sel0 ? v0 : v1;
  assign c = sel0 ? c0 : c1;
  assign l = sel0 ? l0 : l1;
  assign bz = sel0 ? b0 : b1;
  assign dn = sel0 ? d0 : d1;
  assign er = sel0 ? e0 : e1;
  always #5 clk = ~clk;
  function automatic logic [5:0] dots(input int n);
    int m;
    m = n;
    dots = '0;
    while (m > 0) begin
      dots[POS[m % 10]] = 1'b1;
      m = m / 10;
    end
  endfunction
  task automatic model(input logic [15:0] b, input bit lz);
    int d[$];
    exp_c.delete();
    exp_l.delete();
    exp_err = 0;
    for (int i = 3; i >= 0; i--) d.push_back(int'((b >> (4 * i)) & 16'hF));
    while (lz && d.size() > 1 && d[0] == 0) void'(d.pop_front());
    exp_c.push_back(dots(3456));
    exp_l.push_back(0);
    foreach (d[k]) begin
      exp_c.push_back(d[k] > 9 ? 6'd0 : dots(DOTS[d[k]]));
      exp_l.push_back(k == d.size() - 1);
      if (d[k] > 9) exp_err = 1;
    end
  endtask
  task automatic launch(input logic [15:0] b, input bit use0);
    sel0 = use0;
    bcd_in = b;
    start0 = use0;
    start1 = !use0;
    @(negedge clk);
    start0 = 0;
    start1 = 0;
  endtask
  task automatic collect(input logic [15:0] b, input int rmode, input bit poke, input string nm);
    int n, cyc;
    bit held, got_done;
    logic [5:0] hc, ec;
    logic hl, el;
    model(b, !sel0);
    n = exp_c.size();
    held = 0;
    got_done = 0;
    for (cyc = 0; cyc < 400; cyc++) begin
      start0 = 0;
      start1 = 0;
      if (cyc == 0) begin
        checks++;
        if (v !== 1'b1 || er !== 1'b0) begin errors++; $display("FAIL %s first_cell: valid=%b err=%b want valid=1 err=0", nm, v, er); end
      end
      if (held) begin
        checks++;
        if (v !== 1'b1 || c !== hc || l !== hl) begin errors++; $display("FAIL %s hold: valid=%b cell=%b last=%b want 1 %b %b", nm, v, c, l, hc, hl); end
      end
      checks++;
      if (bz !== v) begin errors++; $display("FAIL %s busy: busy=%b want %b", nm, bz, v); end
      if (dn === 1'b1) begin got_done = 1; break; end
      out_ready = rmode == 0 ? 1'b1 : rmode == 1 ? ((cyc % 6 == 0) || (cyc % 6 == 3) || (cyc % 6 == 5)) : 1'($urandom_range(0, 1));
      if (v && out_ready) begin
        checks++;
        if (exp_c.size() == 0) begin errors++; $display("FAIL %s extra_cell: cell=%b want none", nm, c); end
        else begin
          ec = exp_c.pop_front();
          el = exp_l.pop_front();
          if (c !== ec || l !== el) begin errors++; $display("FAIL %s cell: cell=%b last=%b want %b %b", nm, c, l, ec, el); end
        end
        held = 0;
      end else begin
        held = v;
        hc = c;
        hl = l;
      end
      if (poke && v && $urandom_range(0, 1)) begin
        start0 = sel0;
        start1 = !sel0;
        bcd_in = 16'($urandom);
      end
      @(negedge clk);
    end
    checks++;
    if (!got_done || exp_c.size() != 0) begin errors++; $display("FAIL %s done: done_seen=%0d missing=%0d want 1 0", nm, got_done, exp_c.size()); end
    checks++;
    if (er !== exp_err) begin errors++; $display("FAIL %s err_at_done: err=%b want %b", nm, er, exp_err); end
    if (rmode == 0) begin
      checks++;
      if (cyc != n) begin errors++; $display("FAIL %s cycles: got %0d want %0d", nm, cyc, n); end
    end
  endtask
  task automatic after_done(input string nm);
    @(negedge clk);
    checks++;
    if (dn !== 1'b0 || v !== 1'b0 || bz !== 1'b0 || er !== exp_err) begin
      errors++; $display("FAIL %s after_done: done=%b valid=%b busy=%b err=%b want 0 0 0 %b", nm, dn, v, bz, er, exp_err);
    end
  endtask
  task automatic check_zero(input string nm);
    checks++;
    if ({v1, c1, l1, b1, d1, e1, v0, c0, l0, b0, d0, e0} !== '0) begin
      errors++; $display("FAIL %s reset_outputs: dut1=%b%b%b%b%b%b dut0=%b%b%b%b%b%b want all 0", nm, v1, c1, l1, b1, d1, e1, v0, c0, l0, b0, d0, e0);
    end
  endtask
  task automatic test_reset();
    check_zero("power_on");
    rst = 0;
    out_ready = 0;
    launch(16'h0427, 0);
    start0 = 1;
    @(negedge clk);
    start0 = 0;
    rst = 1;
    start1 = 1;
    start0 = 1;
    @(negedge clk);
    check_zero("mid_rst1");
    @(negedge clk);
    check_zero("mid_rst2");
    rst = 0;
    start1 = 0;
    start0 = 0;
    @(negedge clk);
    check_zero("post_rst");
  endtask
  task automatic test_basic();
    launch(16'h0427, 0); collect(16'h0427, 0, 0, "n0427"); after_done("n0427");
    launch(16'h0000, 0); collect(16'h0000, 0, 0, "zero_lz"); after_done("zero_lz");
    launch(16'h0000, 1); collect(16'h0000, 0, 0, "zero_nolz"); after_done("zero_nolz");
  endtask
  task automatic test_backpressure();
    launch(16'h1950, 0); collect(16'h1950, 1, 1, "bp1950"); after_done("bp1950");
  endtask
  task automatic test_error();
    launch(16'h12A3, 0); collect(16'h12A3, 0, 0, "err12A3"); after_done("err12A3");
    repeat (2) @(negedge clk);
    checks++;
    if (er !== 1'b1) begin errors++; $display("FAIL err_hold: err=%b want 1", er); end
    launch(16'h0005, 0); collect(16'h0005, 0, 0, "clr0005"); after_done("clr0005");
  endtask
  task automatic test_back_to_back();
    launch(16'h0031, 0); collect(16'h0031, 0, 0, "b2b_first");
    launch(16'h0008, 0); collect(16'h0008, 0, 0, "b2b_second"); after_done("b2b_second");
  endtask
  task automatic test_random();
    logic [15:0] b;
    for (int t = 0; t < 16; t++) begin
      for (int i = 0; i < 4; i++) begin
        case ($urandom_range(0, 7))
          0, 1, 2: b[4*i +: 4] = 4'd0;
          3: b[4*i +: 4] = 4'($urandom_range(10, 15));
          default: b[4*i +: 4] = 4'($urandom_range(0, 9));
        endcase
      end
      launch(b, t % 3 == 2);
      collect(b, 2, 1, "random");
      after_done("random");
    end
  endtask
  initial begin
    rst = 1;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_error();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
